// File: rtl/bcrypt_pkg.sv
// Shared constants and types for the bcrypt UART output path.
package bcrypt_pkg;

   localparam int unsigned BITS_PER_BYTE      = 8;
   localparam int unsigned WORD_BYTES_DEFAULT = 4;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uartTxState_t;

endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between a word producer and the UART word transmitter.
interface uart_word_tx_if
   import bcrypt_pkg::*;
#(
   parameter int unsigned WORD_BYTES = WORD_BYTES_DEFAULT
) ();

   logic [BITS_PER_BYTE*WORD_BYTES-1:0] wordIn;
   logic                                wordValid;
   logic                                wordReady;

   modport master (
      output wordIn,
      output wordValid,
      input  wordReady
   );

   modport slave (
      input  wordIn,
      input  wordValid,
      output wordReady
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..period-1 and flags the last cycle of each bit.
module uart_baud_gen #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_l,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] period,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cntQ, cntD;

   // period is never 0 here; the transmitter substitutes 1 when latching
   assign tick = (cntQ == period - PRESCALE_W'(1));

   always_comb begin
      cntD = cntQ + PRESCALE_W'(1);
      if (clear || tick) begin
         cntD = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cntQ <= '0;
      end else begin
         cntQ <= cntD;
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// Serialises multi-byte words onto an 8N1 UART line, MSB byte first, LSB bit first,
// with gapless back-to-back words.
module uart_word_tx
   import bcrypt_pkg::*;
#(
   parameter int unsigned WORD_BYTES = WORD_BYTES_DEFAULT,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_l,
   uart_word_tx_if.slave         wordIf,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tx,
   output logic                  busy
);

   localparam int unsigned WORD_W = BITS_PER_BYTE * WORD_BYTES;
   localparam int unsigned BYTE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_BYTES - 1);
   localparam logic [2:0]        LAST_BIT  = 3'(BITS_PER_BYTE - 1);

   uartTxState_t               stateQ, stateD;
   logic [2:0]                 bitQ, bitD;
   logic [BYTE_W-1:0]          byteQ, byteD;
   logic [WORD_W-1:0]          wordQ, wordD;
   logic [PRESCALE_W-1:0]      periodQ, periodD;
   logic                       txQ, txD;
   logic                       tick, accept, lastStop, baudClear;
   logic [BITS_PER_BYTE-1:0]   curByte;
   logic [2:0]                 nextBit;

   assign curByte  = wordQ[WORD_W-1 -: BITS_PER_BYTE];
   assign nextBit  = bitQ + 3'd1;
   assign lastStop = (stateQ == StStop) && tick && (byteQ == LAST_BYTE);

   // Gated by reset_l so the block never advertises readiness while held in reset
   assign wordIf.wordReady = reset_l && ((stateQ == StIdle) || lastStop);
   assign accept           = wordIf.wordValid && wordIf.wordReady;
   assign baudClear        = accept || (stateQ == StIdle);
   assign busy             = (stateQ != StIdle);
   assign tx               = txQ;

   uart_baud_gen #(
      .PRESCALE_W (PRESCALE_W)
   ) baudGen (
      .clk     (clk),
      .reset_l (reset_l),
      .clear   (baudClear),
      .period  (periodQ),
      .tick    (tick)
   );

   // tx is computed from the next state so the line is registered yet has no extra latency
   always_comb begin
      stateD  = stateQ;
      bitD    = bitQ;
      byteD   = byteQ;
      wordD   = wordQ;
      periodD = periodQ;
      txD     = txQ;
      case (stateQ)
         StIdle: begin
            txD = 1'b1;
         end
         StStart: begin
            if (tick) begin
               stateD = StData;
               bitD   = '0;
               txD    = curByte[0];
            end
         end
         StData: begin
            if (tick) begin
               if (bitQ == LAST_BIT) begin
                  stateD = StStop;
                  txD    = 1'b1;
               end else begin
                  bitD = nextBit;
                  txD  = curByte[nextBit];
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (byteQ != LAST_BYTE) begin
                  stateD = StStart;
                  byteD  = byteQ + BYTE_W'(1);
                  wordD  = wordQ << BITS_PER_BYTE;
                  bitD   = '0;
                  txD    = 1'b0;
               end else begin
                  stateD = StIdle;
                  txD    = 1'b1;
               end
            end
         end
         default: begin
            stateD = StIdle;
            txD    = 1'b1;
         end
      endcase

      // Acceptance (from idle or the final stop cycle) starts a fresh word
      if (accept) begin
         stateD  = StStart;
         bitD    = '0;
         byteD   = '0;
         wordD   = wordIf.wordIn;
         periodD = (prescale == '0) ? PRESCALE_W'(1) : prescale;
         txD     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         stateQ  <= StIdle;
         bitQ    <= '0;
         byteQ   <= '0;
         wordQ   <= '0;
         periodQ <= PRESCALE_W'(1);
         txQ     <= 1'b1;
      end else begin
         stateQ  <= stateD;
         bitQ    <= bitD;
         byteQ   <= byteD;
         wordQ   <= wordD;
         periodQ <= periodD;
         txQ     <= txD;
      end
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: expected per-cycle tx levels are queued
// when a word is driven and popped as the line is sampled.
module tb_uart_word_tx;

   logic        clk;
   logic        reset_l;
   logic [15:0] prescale;
   logic        tx;
   logic        busy;

   int nCompared;
   int nMismatched;
   logic expQ[$];

   uart_word_tx_if #(.WORD_BYTES(4)) wIf ();

   uart_word_tx #(
      .WORD_BYTES (4),
      .PRESCALE_W (16)
   ) dut (
      .clk      (clk),
      .reset_l  (reset_l),
      .wordIf   (wIf),
      .prescale (prescale),
      .tx       (tx),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   // Reference framing model: per byte MSB first, start 0, 8 data bits LSB first, stop 1
   function automatic void push_word(input logic [31:0] w, input int p);
      logic [7:0] by;
      for (int b = 3; b >= 0; b--) begin
         by = w[8*b +: 8];
         for (int k = 0; k < p; k++) expQ.push_back(1'b0);
         for (int i = 0; i < 8; i++)
            for (int k = 0; k < p; k++) expQ.push_back(by[i]);
         for (int k = 0; k < p; k++) expQ.push_back(1'b1);
      end
   endfunction

   // Presents a word for one acceptance edge and returns #1 into the first frame cycle
   task automatic drive_word(input logic [31:0] w, input logic [15:0] p);
      @(posedge clk);
      #1;
      wIf.wordIn    = w;
      wIf.wordValid = 1'b1;
      prescale      = p;
      push_word(w, (p == 16'd0) ? 1 : int'(p));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_l       = 1'b0;
      wIf.wordValid = 1'b0;
      wIf.wordIn    = 32'h0;
      prescale      = 16'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nCompared++;
      if (tx !== 1'b1) begin
         nMismatched++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      nCompared++;
      if (wIf.wordReady !== 1'b0) begin
         nMismatched++; $display("FAIL reset_ready: got %b want 0", wIf.wordReady);
      end
      @(posedge clk);
      #1 reset_l = 1'b1;
      @(negedge clk);
      nCompared++;
      if (wIf.wordReady !== 1'b1) begin
         nMismatched++; $display("FAIL post_reset_ready: got %b want 1", wIf.wordReady);
      end
   endtask

   task automatic test_basic();
      logic expTx;
      drive_word(32'h4f727068, 16'd4);
      wIf.wordValid = 1'b0;
      wIf.wordIn    = 32'hdeadbeef;
      for (int c = 1; c <= 160; c++) begin
         @(negedge clk);
         expTx = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL basic_tx c%0d: got %b want %b", c, tx, expTx);
         end
         nCompared++;
         if (busy !== 1'b1) begin
            nMismatched++; $display("FAIL basic_busy c%0d: got %b want 1", c, busy);
         end
         nCompared++;
         if (wIf.wordReady !== (c == 160)) begin
            nMismatched++;
            $display("FAIL basic_ready c%0d: got %b want %b", c, wIf.wordReady, c == 160);
         end
      end
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         nMismatched++; $display("FAIL basic_idle: got busy=%b tx=%b want 0/1", busy, tx);
      end
   endtask

   task automatic test_back_to_back();
      logic expTx;
      logic expRdy;
      drive_word(32'h4f727068, 16'd4);
      wIf.wordIn = 32'h65616e42;
      push_word(32'h65616e42, 4);
      for (int c = 1; c <= 320; c++) begin
         @(negedge clk);
         expTx  = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         expRdy = (c == 160) || (c == 320);
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL b2b_tx c%0d: got %b want %b", c, tx, expTx);
         end
         nCompared++;
         if (busy !== 1'b1) begin
            nMismatched++; $display("FAIL b2b_busy c%0d: got %b want 1", c, busy);
         end
         nCompared++;
         if (wIf.wordReady !== expRdy) begin
            nMismatched++;
            $display("FAIL b2b_ready c%0d: got %b want %b", c, wIf.wordReady, expRdy);
         end
         if (c == 161) wIf.wordValid = 1'b0;
      end
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++; $display("FAIL b2b_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_prescale_zero();
      logic expTx;
      int   lows;
      lows = 0;
      drive_word(32'hffffffff, 16'd0);
      wIf.wordValid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         expTx = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         if (tx === 1'b0) lows++;
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL p0_tx c%0d: got %b want %b", c, tx, expTx);
         end
      end
      nCompared++;
      if (lows != 4) begin
         nMismatched++; $display("FAIL p0_lowcount: got %0d want 4", lows);
      end
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b0 || wIf.wordReady !== 1'b1) begin
         nMismatched++;
         $display("FAIL p0_idle: got busy=%b ready=%b want 0/1", busy, wIf.wordReady);
      end
   endtask

   task automatic test_prescale_change();
      logic expTx;
      drive_word(32'ha5c30f96, 16'd4);
      wIf.wordValid = 1'b0;
      for (int c = 1; c <= 160; c++) begin
         @(negedge clk);
         expTx = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL psc_old_tx c%0d: got %b want %b", c, tx, expTx);
         end
         if (c == 50) prescale = 16'd9;
      end
      drive_word(32'h3c5a01fe, 16'd9);
      wIf.wordValid = 1'b0;
      for (int c = 1; c <= 360; c++) begin
         @(negedge clk);
         expTx = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL psc_new_tx c%0d: got %b want %b", c, tx, expTx);
         end
      end
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++; $display("FAIL psc_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_ignore_busy();
      logic expTx;
      drive_word(32'hc0ffee11, 16'd4);
      for (int c = 1; c <= 160; c++) begin
         @(negedge clk);
         expTx = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL ign_tx c%0d: got %b want %b", c, tx, expTx);
         end
         nCompared++;
         if (wIf.wordReady !== (c == 160)) begin
            nMismatched++;
            $display("FAIL ign_ready c%0d: got %b want %b", c, wIf.wordReady, c == 160);
         end
         if (c < 159) wIf.wordIn = $urandom;
         else wIf.wordValid = 1'b0;
      end
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++; $display("FAIL ign_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      logic expTx;
      drive_word(32'h4f727068, 16'd4);
      wIf.wordValid = 1'b0;
      // Cycle 95 lies in the data bits of byte index 2 (cycles 85..116)
      for (int c = 1; c <= 95; c++) begin
         @(negedge clk);
         expTx = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL rst_pre_tx c%0d: got %b want %b", c, tx, expTx);
         end
      end
      #2 reset_l = 1'b0;
      #1;
      nCompared++;
      if (tx !== 1'b1 || busy !== 1'b0 || wIf.wordReady !== 1'b0) begin
         nMismatched++;
         $display("FAIL rst_async: got tx=%b busy=%b ready=%b want 1/0/0",
                  tx, busy, wIf.wordReady);
      end
      expQ.delete();
      @(posedge clk);
      @(posedge clk);
      #1 reset_l = 1'b1;
      @(negedge clk);
      nCompared++;
      if (wIf.wordReady !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
         nMismatched++;
         $display("FAIL rst_release: got ready=%b tx=%b busy=%b want 1/1/0",
                  wIf.wordReady, tx, busy);
      end
      drive_word(32'h12345678, 16'd4);
      wIf.wordValid = 1'b0;
      for (int c = 1; c <= 160; c++) begin
         @(negedge clk);
         expTx = (expQ.size() > 0) ? expQ.pop_front() : 1'b1;
         nCompared++;
         if (tx !== expTx) begin
            nMismatched++; $display("FAIL rst_post_tx c%0d: got %b want %b", c, tx, expTx);
         end
      end
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b0) begin
         nMismatched++; $display("FAIL rst_post_idle: got busy=%b want 0", busy);
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_prescale_zero();
      test_prescale_change();
      test_ignore_busy();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 4, bytes per input word.
REQ-002 The block SHALL have parameter PRESCALE_W, default 16, width of the prescale input.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 reset_l  input  1  reset, asynchronous, active-low.
REQ-005 wordIn  input  8*WORD_BYTES  word to transmit, e.g. a ciphertext word from the bcrypt core.
REQ-006 wordValid  input  1  wordIn holds a valid word.
REQ-007 wordReady  output  1  block accepts wordIn on this posedge when wordValid=1.
REQ-008 prescale  input  PRESCALE_W  clk cycles per UART bit.
REQ-009 tx  output  1  serial line, 8N1, idle high.
REQ-010 busy  output  1  a frame is being shifted out.

Function
REQ-011 Handshake: a word SHALL be accepted at a posedge where wordValid=1 and wordReady=1; wordIn and prescale are latched at that edge.
REQ-012 Effective bit period P SHALL be the latched prescale, with 0 treated as 1; prescale changes after acceptance SHALL have no effect until the next acceptance.
REQ-013 States: IDLE, START, DATA, STOP. IDLE→START on acceptance; START→DATA after P cycles; DATA→STOP after 8 bits of P cycles each; STOP→START (next byte) after P cycles if byte index < WORD_BYTES-1, else →IDLE or →START (new word).
REQ-014 Byte order: most-significant byte first (word 0x4f727068 sends 0x4f,0x72,0x70,0x68); bit order within a byte LSB first.
REQ-015 tx SHALL be registered: 0 during START, the data bit during DATA, 1 during STOP and IDLE.
REQ-016 Latency: tx SHALL fall in the first cycle after the acceptance edge.
REQ-017 No idle cycles SHALL be inserted between bytes of one word; one word occupies exactly WORD_BYTES*10*P cycles.
REQ-018 wordReady SHALL be 1 in IDLE and in the last cycle of the last STOP bit of the last byte; it SHALL be 0 otherwise. Acceptance in that cycle SHALL go straight to START, giving gapless back-to-back words.
REQ-019 busy SHALL be 1 in every non-IDLE state.
REQ-020 Counters: the baud counter counts 0..P-1 and wraps; the bit counter counts 0..7; the byte counter counts 0..WORD_BYTES-1. All are cleared on entry to START of a new word.
REQ-021 wordValid/wordIn activity while wordReady=0 SHALL be ignored.

Reset
REQ-022 While reset_l=0: tx=1, busy=0, wordReady=0, state IDLE, all counters and the shift register 0.
REQ-023 After reset_l rises, wordReady SHALL be 1 from the first cycle.
REQ-024 Reset asserted mid-frame SHALL drive tx to 1 immediately (asynchronously) and discard the in-flight word; no partial byte resumes.

Structure
REQ-025 The state enum type and the constants BITS_PER_BYTE=8 and the default WORD_BYTES SHALL live in shared package bcrypt_pkg.
REQ-026 The baud-tick counter SHALL be one sub-module, uart_baud_gen: inputs clk, reset_l, clear, period; output tick on the last cycle of each bit period.

Verification
REQ-027 wordIn=0x4f727068, prescale=4 → tx: 0,1,1,1,1,0,0,1,0,1 (byte 0x4f), each bit 4 cycles, then 0x72, 0x70, 0x68; busy high for 160 cycles; wordReady high again on cycle 160.
REQ-028 Back-to-back, wordValid held: 0x4f727068 then 0x65616e42, prescale=4 → second start bit begins on cycle 161 with no idle high bit; 320 cycles total.
REQ-029 prescale=0, word 0xFFFFFFFF → P treated as 1; 40-cycle frame; tx low only in the 4 start-bit cycles.
REQ-030 prescale changed 4→9 during byte 1 → the remainder of the word stays at 4 cycles/bit; the next word uses 9.
REQ-031 reset_l pulsed low during DATA of byte 2 → tx=1 and busy=0 immediately; after release wordReady=1; a new word 0x12345678 transmits cleanly starting with byte 0x12.
REQ-032 wordValid=1 while busy (wordReady=0), wordIn changed each cycle → the transmitted word equals the value latched at acceptance.
